// File: rtl/key_pkg.sv
// Shared types and constants for the scan-code display buffer.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_BREAK = 2'd2
  } kbd_state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    unique case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/key_display_buf.sv
// Keyboard scan-byte history shown as hex digits, with a key-press counter.
// Optional break/repeat filter enabled by macro KEY_DISPLAY_BREAK_FILTER_EN.
module key_display_buf
  import key_pkg::*;
#(
  parameter int unsigned N_BYTES = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  input  logic                    clear,
  output logic [14*N_BYTES-1:0]   hex,
  output logic [CNT_W-1:0]        count,
  output logic                    pressed
);

  localparam int unsigned N_DIGITS = 2 * N_BYTES;

  logic [N_BYTES-1:0][7:0] data_q;
  logic [N_BYTES-1:0]      written_q;
  logic                    xfer_c;
  logic                    shift_c;

  assign in_ready = !rst && !clear;
  assign xfer_c   = in_valid && in_ready;

`ifdef KEY_DISPLAY_BREAK_FILTER_EN
  kbd_state_t state_q;

  // A transfer shifts only for a fresh make code; break sequences and repeats are swallowed.
  always_comb begin
    shift_c = 1'b0;
    if (xfer_c && state_q != ST_BREAK && in_data != BREAK_CODE)
      shift_c = !(state_q == ST_HELD && in_data == data_q[0]);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_IDLE;
      pressed <= 1'b0;
    end else if (xfer_c) begin
      unique case (state_q)
        ST_BREAK: begin
          state_q <= ST_IDLE;
          pressed <= 1'b0;
        end
        default: begin
          if (in_data == BREAK_CODE) begin
            state_q <= ST_BREAK;
            pressed <= 1'b0;
          end else begin
            state_q <= ST_HELD;
            pressed <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign shift_c = xfer_c;
  assign pressed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data_q    <= '0;
      written_q <= '0;
      count     <= '0;
    end else if (shift_c) begin
      for (int unsigned i = N_BYTES - 1; i > 0; i--) begin
        data_q[i]    <= data_q[i-1];
        written_q[i] <= written_q[i-1];
      end
      data_q[0]    <= in_data;
      written_q[0] <= 1'b1;
      count        <= count + CNT_W'(1);
    end
  end

  // Even digits take the low nibble of a slot, odd digits the high nibble.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic [3:0] nibble;
    logic [6:0] seg;

    if (k % 2 == 0) begin : g_lo
      assign nibble = data_q[k/2][3:0];
    end else begin : g_hi
      assign nibble = data_q[k/2][7:4];
    end

    hex7seg u_hex7seg (
      .nibble (nibble),
      .seg_c  (seg)
    );

    assign hex[7*k +: 7] = written_q[k/2] ? seg : SEG_BLANK;
  end

endmodule
